// File: rtl/goomba_pkg.sv
// Shared types and constants for the goomba spawn path.
// Screen limits match the goomba instance's coordinate space.
package goomba_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    CONFIRM,
    REPORT
  } spawn_state_t;

  localparam int         N_SLOTS_DEFAULT = 4;
  localparam logic [9:0] SHIFT_PX        = 10'd40;
  localparam logic [9:0] SCREEN_X_MAX    = 10'd639;
  localparam logic [9:0] SCREEN_Y_MAX    = 10'd479;

endpackage

// File: rtl/goomba_spawn_scheduler_rr_pick.sv
// Round-robin first-free finder: scans the free mask
// starting at ptr and wraps, returning the first hit.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  free,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && free[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/goomba_spawn_scheduler.sv
// Goomba spawn scheduler: accepts level spawn requests,
// grants a free slot round-robin and reports the outcome.
module goomba_spawn_scheduler
  import goomba_pkg::*;
#(
  parameter int         N_SLOTS  = N_SLOTS_DEFAULT,
  parameter logic [9:0] SHIFT_PX = goomba_pkg::SHIFT_PX,
  parameter int         IW       = $clog2(N_SLOTS)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               req_valid,
  input  logic [9:0]         req_x,
  input  logic [9:0]         req_y,
  output logic               req_ready,
  input  logic               Shift,
  input  logic               clear_all,
  input  logic [N_SLOTS-1:0] isAlive,
  output logic [N_SLOTS-1:0] start,
  output logic [N_SLOTS-1:0] kill,
  output logic [9:0]         spawnX,
  output logic [9:0]         spawnY,
  output logic               done,
  output logic               done_ok,
  output logic [IW-1:0]      done_slot,
  output logic [IW:0]        alive_count
);

  spawn_state_t state, nxt;

  logic [9:0]         hold_x, hold_y;
  logic [IW-1:0]      rr_ptr, grant;
  logic               ok_r, ok_n;
  logic [N_SLOTS-1:0] kill_r;
  logic [IW:0]        cnt_r, cnt_n;
  logic               found;
  logic [IW-1:0]      pick;
  logic               accept;
  logic               shift_live;
  logic               shift_wrap;
  logic               fire;

  rr_pick #(
    .N  (N_SLOTS),
    .IW (IW)
  ) u_pick (
    .free  (~isAlive),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (pick)
  );

  assign req_ready  = (state == IDLE) && !clear_all;
  assign accept     = req_ready && req_valid;
  assign shift_live = Shift && (state == SELECT || state == ISSUE);
  assign shift_wrap = shift_live && (hold_x < SHIFT_PX);
  // a wrapping shift or a clear cancels the pulse in ISSUE
  assign fire       = (state == ISSUE) && !clear_all && !shift_wrap;

  assign spawnX      = hold_x;
  assign spawnY      = hold_y;
  assign kill        = kill_r;
  assign done        = (state == REPORT);
  assign done_ok     = done && ok_r;
  assign done_slot   = grant;
  assign alive_count = cnt_r;

  always_comb begin
    start = '0;
    if (fire) start[grant] = 1'b1;
  end

  always_comb begin
    cnt_n = '0;
    for (int i = 0; i < N_SLOTS; i++)
      cnt_n = cnt_n + (IW+1)'(isAlive[i]);
  end

  always_comb begin
    nxt  = state;
    ok_n = ok_r;
    unique case (state)
      IDLE: begin
        if (accept) nxt = SELECT;
      end
      SELECT: begin
        if (clear_all || shift_wrap || !found) begin
          nxt  = REPORT;
          ok_n = 1'b0;
        end else begin
          nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (clear_all || shift_wrap) begin
          nxt  = REPORT;
          ok_n = 1'b0;
        end else begin
          nxt = CONFIRM;
        end
      end
      CONFIRM: begin
        nxt  = REPORT;
        ok_n = clear_all ? 1'b0 : isAlive[grant];
      end
      REPORT: begin
        nxt = IDLE;
      end
      default: begin
        nxt  = IDLE;
        ok_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      ok_r   <= 1'b0;
      kill_r <= '0;
      cnt_r  <= '0;
      hold_x <= '0;
      hold_y <= '0;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= nxt;
      ok_r   <= ok_n;
      kill_r <= {N_SLOTS{clear_all}};
      cnt_r  <= cnt_n;
      if (accept) begin
        hold_x <= req_x;
        hold_y <= req_y;
      end else if (shift_live && !shift_wrap && !clear_all) begin
        hold_x <= hold_x - SHIFT_PX;
      end
      if (state == SELECT && found)
        grant <= pick;
      if (fire)
        rr_ptr <= (grant == IW'(N_SLOTS - 1)) ? '0 : grant + IW'(1);
    end
  end

endmodule

// File: tb/tb_goomba_spawn_scheduler.sv
// Scoreboard bench for goomba_spawn_scheduler: stimulus pushes
// expected start/done events, a negedge monitor pops and compares.
module tb_goomba_spawn_scheduler;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       req_valid;
  logic [9:0] req_x, req_y;
  logic       req_ready;
  logic       Shift;
  logic       clear_all;
  logic [3:0] isAlive;
  logic [3:0] start;
  logic [3:0] kill;
  logic [9:0] spawnX, spawnY;
  logic       done;
  logic       done_ok;
  logic [1:0] done_slot;
  logic [2:0] alive_count;

  goomba_spawn_scheduler #(
    .N_SLOTS  (4),
    .SHIFT_PX (10'd40)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_ready   (req_ready),
    .Shift       (Shift),
    .clear_all   (clear_all),
    .isAlive     (isAlive),
    .start       (start),
    .kill        (kill),
    .spawnX      (spawnX),
    .spawnY      (spawnY),
    .done        (done),
    .done_ok     (done_ok),
    .done_slot   (done_slot),
    .alive_count (alive_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] st;
    logic [9:0] x;
    logic [9:0] y;
    int         cyc;
  } exp_start_t;

  typedef struct {
    logic       ok;
    logic [1:0] slot;
    int         cyc;
  } exp_done_t;

  exp_start_t sq[$];
  exp_done_t  dq[$];
  exp_start_t es;
  exp_done_t  ed;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic auto_alive = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_start(input logic [3:0] st, input logic [9:0] x,
                           input logic [9:0] y, input int c);
    sq.push_back('{st: st, x: x, y: y, cyc: c});
  endtask

  task automatic exp_done(input logic ok, input logic [1:0] slot,
                          input int c);
    dq.push_back('{ok: ok, slot: slot, cyc: c});
  endtask

  // Starts at posedge+1 in IDLE, returns in the T+3 window.
  task automatic send(input logic [9:0] x, input logic [9:0] y,
                      input logic sh, input logic clr);
    req_valid = 1'b1;
    req_x     = x;
    req_y     = y;
    tick();
    req_valid = 1'b0;
    if (sh) Shift = 1'b1;
    tick();
    Shift = 1'b0;
    if (clr) clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(req_ready), 32'd1);
  endtask

  always @(negedge Clk) begin
    if (start !== 4'b0000) begin
      tests++;
      if (sq.size() == 0) begin
        fails++;
        $display("FAIL start_unexpected: start=%b cyc=%0d expected none",
                 start, cyc);
      end else begin
        es = sq.pop_front();
        if (start !== es.st || spawnX !== es.x || spawnY !== es.y ||
            cyc != es.cyc) begin
          fails++;
          $display("FAIL start: got %b x=%0d y=%0d cyc=%0d expected %b x=%0d y=%0d cyc=%0d",
                   start, spawnX, spawnY, cyc, es.st, es.x, es.y, es.cyc);
        end
      end
      if (auto_alive) isAlive = isAlive | start;
    end
    if (done === 1'b1) begin
      tests++;
      if (dq.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: done_ok=%b cyc=%0d expected none",
                 done_ok, cyc);
      end else begin
        ed = dq.pop_front();
        if (done_ok !== ed.ok || cyc != ed.cyc ||
            (ed.ok && done_slot !== ed.slot)) begin
          fails++;
          $display("FAIL done: got ok=%b slot=%0d cyc=%0d expected ok=%b slot=%0d cyc=%0d",
                   done_ok, done_slot, cyc, ed.ok, ed.slot, ed.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    Reset_n   = 1'b0;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    Shift     = 1'b0;
    clear_all = 1'b0;
    isAlive   = 4'b0000;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_outs", {start, kill, done, done_ok, done_slot, alive_count},
        32'd0);
    chk("rst_spawn", {spawnX, spawnY}, 32'd0);
    #10;
    Reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // basic spawn into slot 0
    auto_alive = 1'b1;
    t = cyc;
    exp_start(4'b0001, 10'd200, 10'd300, t + 2);
    exp_done(1'b1, 2'd0, t + 4);
    send(10'd200, 10'd300, 1'b0, 1'b0);
    chk("busy_ready", 32'(req_ready), 32'd0);
    wait_idle();

    // round-robin with slots 0 and 2 alive
    isAlive = 4'b0101;
    t = cyc;
    exp_start(4'b0010, 10'd120, 10'd400, t + 2);
    exp_done(1'b1, 2'd1, t + 4);
    send(10'd120, 10'd400, 1'b0, 1'b0);
    wait_idle();
    t = cyc;
    exp_start(4'b1000, 10'd500, 10'd410, t + 2);
    exp_done(1'b1, 2'd3, t + 4);
    send(10'd500, 10'd410, 1'b0, 1'b0);
    wait_idle();

    // pool full: drop at T+2, no start
    chk("all_alive", 32'(isAlive), 32'hF);
    t = cyc;
    exp_done(1'b0, 2'd0, t + 2);
    send(10'd50, 10'd60, 1'b0, 1'b0);
    wait_idle();

    // alive_count lags isAlive by one cycle
    chk("cnt_full", 32'(alive_count), 32'd4);
    isAlive = 4'b0000;
    #1;
    chk("cnt_lag", 32'(alive_count), 32'd4);
    tick();
    chk("cnt_zero", 32'(alive_count), 32'd0);

    // shift in SELECT: 100 -> 60
    t = cyc;
    exp_start(4'b0001, 10'd60, 10'd300, t + 2);
    exp_done(1'b1, 2'd0, t + 4);
    send(10'd100, 10'd300, 1'b1, 1'b0);
    wait_idle();

    // shift with x=30 would wrap: dropped
    t = cyc;
    exp_done(1'b0, 2'd0, t + 2);
    send(10'd30, 10'd300, 1'b1, 1'b0);
    wait_idle();

    // shift with x exactly SHIFT_PX lands on 0
    t = cyc;
    exp_start(4'b0010, 10'd0, 10'd222, t + 2);
    exp_done(1'b1, 2'd1, t + 4);
    send(10'd40, 10'd222, 1'b1, 1'b0);
    wait_idle();

    // clear_all in ISSUE: no start, kill one cycle, dropped
    auto_alive = 1'b0;
    isAlive    = 4'b0000;
    t = cyc;
    exp_done(1'b0, 2'd0, t + 3);
    send(10'd300, 10'd200, 1'b0, 1'b1);
    chk("kill_on", 32'(kill), 32'hF);
    tick();
    chk("kill_off", 32'(kill), 32'h0);
    wait_idle();

    // rr_ptr unchanged by suppressed start: slot 2 next
    auto_alive = 1'b1;
    t = cyc;
    exp_start(4'b0100, 10'd310, 10'd210, t + 2);
    exp_done(1'b1, 2'd2, t + 4);
    send(10'd310, 10'd210, 1'b0, 1'b0);
    wait_idle();

    // clear_all in IDLE: kill pulse, no done
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    chk("idle_kill_on", 32'(kill), 32'hF);
    tick();
    chk("idle_kill_off", 32'(kill), 32'h0);

    // reset dropped in CONFIRM
    t = cyc;
    exp_start(4'b1000, 10'd77, 10'd88, t + 2);
    send(10'd77, 10'd88, 1'b0, 1'b0);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_outs", {start, kill, done, done_ok, done_slot, alive_count},
        32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_spawn", {spawnX, spawnY}, 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    chk("rel_ready", 32'(req_ready), 32'd1);

    // rr_ptr back to 0 after reset
    isAlive = 4'b0000;
    t = cyc;
    exp_start(4'b0001, 10'd444, 10'd333, t + 2);
    exp_done(1'b1, 2'd0, t + 4);
    send(10'd444, 10'd333, 1'b0, 1'b0);
    wait_idle();
    tick();
    tick();

    chk("start_q_empty", 32'(sq.size()), 32'd0);
    chk("done_q_empty", 32'(dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/goomba_spawn_scheduler.md
# goomba_spawn_scheduler

Sequences a fixed pool of goomba instances. It accepts spawn requests from the level-data reader over a valid/ready handshake and picks a free slot round-robin. It then drives that slot's one-cycle `start` pulse together with the shared `spawnX`/`spawnY` bus, and reports the completion or drop of each request. It sits between the level loader and the goomba instances in the top level, and also owns the global clear that kills every slot on level reset or death.

## Interface
- `N_SLOTS`, 4: number of goomba instances managed; `N_SLOTS` ≥ 2, and the slot index is `$clog2(N_SLOTS)` bits wide.
- `SHIFT_PX`, 10'd40: X correction applied to a held request per `Shift` pulse; matches the goomba scroll step.
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: spawn request present.
- `req_x`, `req_y` in 10 each: spawn position in screen pixels; `req_y` is the ground line.
- `req_ready` out 1: scheduler can accept a request.
- `Shift` in 1: one-cycle screen-scroll pulse.
- `clear_all` in 1: one-cycle global clear.
- `isAlive` in N_SLOTS: per-slot `isAlive_out` from the goombas.
- `start` out N_SLOTS: one-hot spawn pulse.
- `kill` out N_SLOTS: per-slot kill.
- `spawnX`, `spawnY` out 10 each: shared spawn position bus.
- `done` out 1: one-cycle pulse, request finished.
- `done_ok` out 1: qualifies `done`; 1 means spawned, 0 means dropped.
- `done_slot` out $clog2(N_SLOTS): slot used, valid with `done && done_ok`.
- `alive_count` out $clog2(N_SLOTS)+1: popcount of `isAlive`, registered.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - SELECT: choose a slot.
  - ISSUE: drive `start`.
  - CONFIRM: check `isAlive`.
  - REPORT: drive `done`.
- IDLE → SELECT when `req_valid && req_ready`; `req_x`/`req_y` are latched into `hold_x`/`hold_y`.
- SELECT: the free set is `~isAlive`. Search it round-robin starting at `rr_ptr`.
  - If a free slot exists: register `grant`, go to ISSUE.
  - If none exists: go to REPORT with `done_ok`=0.
- ISSUE: `start[grant]`=1 for exactly one cycle. Set `rr_ptr` = `grant`+1 mod N_SLOTS, then go to CONFIRM.
- CONFIRM: if `isAlive[grant]`=1, go to REPORT with `done_ok`=1; otherwise go to REPORT with `done_ok`=0.
- REPORT: `done`=1 for one cycle, then go to IDLE.
- `spawnX`/`spawnY` always drive `hold_x`/`hold_y`. They are stable from SELECT through CONFIRM.
- `Shift` in SELECT or ISSUE (before `start` fires):
  - If `hold_x` ≥ `SHIFT_PX`: `hold_x` -= `SHIFT_PX`, and the request continues.
  - Otherwise (it would wrap): abort to REPORT with `done_ok`=0; no `start` is issued.
- `Shift` in IDLE, CONFIRM or REPORT is ignored.
- `clear_all`: drive `kill` all-ones for exactly the next cycle. Any state moves to REPORT with `done_ok`=0; if already IDLE, go to IDLE with no `done`.
  - If `clear_all` coincides with ISSUE, `start` is suppressed that cycle.
- `kill` is otherwise all-zeros; `start` and `kill` are never both set for the same slot.
- Arithmetic is 10-bit unsigned; no other wrap is permitted.

## Timing
- Reset values:
  - state IDLE; `rr_ptr`=0; `hold_x`/`hold_y`=0.
  - `start`=0, `kill`=0, `done`=0, `done_ok`=0, `done_slot`=0, `alive_count`=0.
  - `req_ready`=1 after reset release.
- Accept at cycle T. Then SELECT at T+1, `start` at T+2, CONFIRM at T+3 and `done` at T+4. The next accept is possible at T+5.
- A dropped request with no free slot gives `done` at T+2.
- `req_ready` is low from T+1 through T+4.
- `alive_count` lags `isAlive` by one cycle.
- `Reset_n` low mid-operation: all outputs take their reset values immediately; the held request is lost with no `done`.

## Structure
- Package `goomba_pkg`: state enum `spawn_state_t`, `SHIFT_PX`, the screen X/Y limits shared with the goomba instance, and `N_SLOTS_DEFAULT`.
- Sub-module `rr_pick`: combinational round-robin first-free finder. Inputs are the free mask and pointer; outputs are found and index.

## Test plan
- Basic spawn: all dead, request (200,300) → `start`=0001 at T+2, `spawnX`=200, `spawnY`=300, then `done`/`done_ok`=1 with `done_slot`=0 at T+4.
- Round-robin: after slot 0 spawns with slots 0 and 2 alive, the next request → `start`=0010, then the next → `start`=1000.
- Pool full: `isAlive`=1111, request → `done`=1 with `done_ok`=0 at T+2, and `start` never asserted.
- Shift during SELECT with `req_x`=100 → `start` carries `spawnX`=60. With `req_x`=30 → `done_ok`=0 and no `start`.
- `clear_all` in ISSUE → `start` suppressed, `kill`=1111 for one cycle, then `done` with `done_ok`=0.
- `Reset_n` dropped in CONFIRM → outputs at reset values in the same cycle, `req_ready`=1 after release, `rr_ptr`=0.
